// File: rtl/sigma_delta_pkg.sv
// Shared sizing helpers and default-configuration types for the multi-channel
// sigma-delta ADC front end.
package sigma_delta_pkg;

    // CIC bit growth G = N * log2(R); integrator/comb words carry one extra bit.
    function automatic int cic_gain_bits(input int stages, input int bosr);
        return stages * $clog2(bosr);
    endfunction

    function automatic int cic_acc_bits(input int stages, input int bosr);
        return cic_gain_bits(stages, bosr) + 1;
    endfunction

    function automatic int ch_bits(input int num_ch);
        return (num_ch > 1) ? $clog2(num_ch) : 1;
    endfunction

    // Frames discarded after reset while the CIC memory fills with real input.
    function automatic int warmup_frames(input int stages);
        return stages + 1;
    endfunction

    localparam int DEF_NUM_CH        = 2;
    localparam int DEF_BOSR          = 256;
    localparam int DEF_CIC_STAGES    = 3;
    localparam int DEF_OUT_WDTH      = 16;
    localparam int CH_W              = ch_bits(DEF_NUM_CH);
    localparam int DEF_ACC_W         = cic_acc_bits(DEF_CIC_STAGES, DEF_BOSR);
    localparam int WARMUP_FRAMES     = warmup_frames(DEF_CIC_STAGES);

    typedef logic        [DEF_ACC_W-1:0]    acc_t;
    typedef logic signed [DEF_OUT_WDTH-1:0] sample_t;

endpackage

// File: rtl/cic_decimator.sv
// One channel of CIC decimation: integrators at the input rate, a comb pipeline
// stepped by externally supplied enables, then offset removal, saturation and scaling.
module cic_decimator
    import sigma_delta_pkg::*;
#(
    parameter int BOSR       = 256,
    parameter int CIC_STAGES = 3,
    parameter int OUT_WDTH   = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       din,
    input  logic [CIC_STAGES-1:0]      comb_en,
    input  logic                       scale_en,
    output logic signed [OUT_WDTH-1:0] sample
);
    localparam int G     = cic_gain_bits(CIC_STAGES, BOSR);
    localparam int ACC_W = G + 1;

    logic [ACC_W-1:0] integ    [CIC_STAGES];
    logic [ACC_W-1:0] integ_in [CIC_STAGES];
    logic [ACC_W-1:0] comb_in  [CIC_STAGES];
    logic [ACC_W-1:0] comb_dly [CIC_STAGES];
    logic [ACC_W-1:0] comb_p   [CIC_STAGES];

    // Comb output spans 0..2^G; centre it, clip the single +2^(G-1) code, then truncate.
    function automatic logic signed [OUT_WDTH-1:0] sat_scale(input logic [ACC_W-1:0] c);
        logic signed [ACC_W-1:0] half;
        logic signed [ACC_W-1:0] s;
        logic signed [ACC_W-1:0] sh;
        half = $signed(ACC_W'(1) << (G - 1));
        s    = $signed(c - half);
        if (s >= half) s = half - $signed(ACC_W'(1));
        sh   = s >>> (G - OUT_WDTH);
        return sh[OUT_WDTH-1:0];
    endfunction

    assign integ_in[0] = {{(ACC_W-1){1'b0}}, din};
    assign comb_in[0]  = integ[CIC_STAGES-1];
    for (genvar k = 1; k < CIC_STAGES; k++) begin : g_chain
        assign integ_in[k] = integ[k-1];
        assign comb_in[k]  = comb_p[k-1];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < CIC_STAGES; k++) begin
                integ[k]    <= '0;
                comb_dly[k] <= '0;
                comb_p[k]   <= '0;
            end
            sample <= '0;
        end else begin
            for (int k = 0; k < CIC_STAGES; k++) begin
                integ[k] <= integ[k] + integ_in[k];
                // comb stage k: one register per stage, advanced by its own enable
                if (comb_en[k]) begin
                    comb_p[k]   <= comb_in[k] - comb_dly[k];
                    comb_dly[k] <= comb_in[k];
                end
            end
            // scale stage
            if (scale_en) sample <= sat_scale(comb_p[CIC_STAGES-1]);
        end
    end

endmodule

// File: rtl/sigma_delta_adc_mc.sv
// Multi-channel sigma-delta ADC front end: per-channel CIC decimators, shared
// decimation timing, warm-up suppression and a channel-tagged valid/ready frame stream.
module sigma_delta_adc_mc
    import sigma_delta_pkg::*;
#(
    parameter int NUM_CH     = 2,
    parameter int BOSR       = 256,
    parameter int CIC_STAGES = 3,
    parameter int OUT_WDTH   = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_CH-1:0]             adc_lvds_pin,
    output logic [NUM_CH-1:0]             adc_fb_pin,
    output logic signed [OUT_WDTH-1:0]    adc_data,
    output logic [ch_bits(NUM_CH)-1:0]    adc_ch,
    output logic                          adc_valid,
    input  logic                          adc_ready,
    output logic                          adc_overflow
);
    localparam int CW     = ch_bits(NUM_CH);
    localparam int WARMUP = warmup_frames(CIC_STAGES);
    localparam int WU_W   = $clog2(WARMUP + 1);
    localparam int DEC_W  = $clog2(BOSR);

    typedef enum logic {IDLE, SEND} state_t;

    logic [NUM_CH-1:0]          adc_in;
    logic [DEC_W-1:0]           dec_cnt;
    logic                       dec_tick;
    logic [CIC_STAGES:0]        vld_pipe;
    logic [CIC_STAGES:0]        stage_en;
    logic [WU_W-1:0]            wu_cnt;
    logic                       warm;
    logic                       frame_avail;
    logic                       frame_new;
    logic signed [OUT_WDTH-1:0] sample    [NUM_CH];
    logic signed [OUT_WDTH-1:0] frame_buf [NUM_CH];
    state_t                     state, state_nxt;
    logic [CW-1:0]              idx, idx_nxt;
    logic                       last_ch;
    logic                       load_frame;
    logic                       set_ovf;

    assign adc_fb_pin = adc_in;
    assign dec_tick   = (dec_cnt == DEC_W'(BOSR - 1));
    // stage_en[k] is dec_tick delayed k cycles; vld_pipe[N] marks the scaled frame ready
    assign stage_en    = {vld_pipe[CIC_STAGES-1:0], dec_tick};
    assign frame_avail = vld_pipe[CIC_STAGES];
    assign warm        = (wu_cnt == WU_W'(WARMUP));
    assign frame_new   = frame_avail & warm;

    always_ff @(posedge clk) begin
        if (rst) begin
            adc_in   <= '0;
            dec_cnt  <= '0;
            vld_pipe <= '0;
            wu_cnt   <= '0;
        end else begin
            adc_in   <= adc_lvds_pin;
            dec_cnt  <= dec_cnt + DEC_W'(1);
            vld_pipe <= {vld_pipe[CIC_STAGES-1:0], dec_tick};
            if (frame_avail && !warm) wu_cnt <= wu_cnt + WU_W'(1);
        end
    end

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        cic_decimator #(
            .BOSR       (BOSR),
            .CIC_STAGES (CIC_STAGES),
            .OUT_WDTH   (OUT_WDTH)
        ) u_cic (
            .clk      (clk),
            .rst      (rst),
            .din      (adc_in[c]),
            .comb_en  (stage_en[CIC_STAGES-1:0]),
            .scale_en (stage_en[CIC_STAGES]),
            .sample   (sample[c])
        );
    end

    // A frame arriving while one is in flight is dropped whole, unless the
    // in-flight frame's last channel is accepted in that very cycle.
    always_comb begin
        state_nxt  = state;
        idx_nxt    = idx;
        load_frame = 1'b0;
        set_ovf    = 1'b0;
        last_ch    = (idx == CW'(NUM_CH - 1));
        unique case (state)
            IDLE: begin
                if (frame_new) begin
                    load_frame = 1'b1;
                    idx_nxt    = '0;
                    state_nxt  = SEND;
                end
            end
            SEND: begin
                if (adc_ready && last_ch) begin
                    idx_nxt = '0;
                    if (frame_new) load_frame = 1'b1;
                    else           state_nxt  = IDLE;
                end else begin
                    if (adc_ready) idx_nxt = idx + CW'(1);
                    if (frame_new) set_ovf = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            idx          <= '0;
            adc_overflow <= 1'b0;
            for (int c = 0; c < NUM_CH; c++) frame_buf[c] <= '0;
        end else begin
            state <= state_nxt;
            idx   <= idx_nxt;
            if (set_ovf)    adc_overflow <= 1'b1;
            if (load_frame) frame_buf    <= sample;
        end
    end

    assign adc_valid = (state == SEND);
    assign adc_ch    = idx;
    assign adc_data  = frame_buf[idx];

endmodule

// File: tb/tb_sigma_delta_adc_mc.sv
// Directed bench for sigma_delta_adc_mc at the default configuration (2 ch, R=256, N=3, 16 bit).
`timescale 1ns/1ps
module tb_sigma_delta_adc_mc;
    import sigma_delta_pkg::*;

    localparam int NUM_CH = 2;
    localparam int BOSR   = 256;
    // Tick m falls in cycle 256*(m+1)-1; frames 0..3 are warm-up, frame 4 ticks
    // in cycle 1279 and appears 5 cycles later.
    localparam int FIRST  = 1284;
    localparam sample_t MAXP = 16'sd32767;
    localparam sample_t MINN = -16'sd32768;

    logic        clk;
    logic        rst;
    logic [1:0]  adc_lvds_pin;
    logic [1:0]  pin_static;
    logic        toggle_en;
    logic [1:0]  adc_fb_pin;
    sample_t     adc_data;
    logic [0:0]  adc_ch;
    logic        adc_valid;
    logic        adc_ready;
    logic        adc_overflow;
    int          n_chk;
    int          n_fail;

    sigma_delta_adc_mc #(
        .NUM_CH     (2),
        .BOSR       (256),
        .CIC_STAGES (3),
        .OUT_WDTH   (16)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .adc_lvds_pin (adc_lvds_pin),
        .adc_fb_pin   (adc_fb_pin),
        .adc_data     (adc_data),
        .adc_ch       (adc_ch),
        .adc_valid    (adc_valid),
        .adc_ready    (adc_ready),
        .adc_overflow (adc_overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pin driver: static level or both channels toggling every cycle.
    initial begin
        adc_lvds_pin = 2'b00;
        forever begin
            @(negedge clk);
            adc_lvds_pin = toggle_en ? ~adc_lvds_pin : pin_static;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Leaves the bench 1 ns into cycle 0 (decimation counter = 0).
    task automatic reset_dut(input int ncyc);
        rst = 1'b1;
        repeat (ncyc) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        pin_static = 2'b01;
        toggle_en  = 1'b0;
        adc_ready  = 1'b1;
        reset_dut(2);
        n_chk++; if (adc_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %b, expected 0", adc_valid); end
        n_chk++; if (adc_ch !== 1'b0) begin n_fail++; $display("FAIL rst_ch: got %0d, expected 0", adc_ch); end
        n_chk++; if (adc_data !== 16'sd0) begin n_fail++; $display("FAIL rst_data: got %0d, expected 0", adc_data); end
        n_chk++; if (adc_overflow !== 1'b0) begin n_fail++; $display("FAIL rst_ovf: got %b, expected 0", adc_overflow); end
        n_chk++; if (adc_fb_pin !== 2'b00) begin n_fail++; $display("FAIL rst_fb: got %b, expected 00", adc_fb_pin); end
        step();
        n_chk++; if (adc_fb_pin !== 2'b01) begin n_fail++; $display("FAIL fb_follow: got %b, expected 01", adc_fb_pin); end
    endtask

    task automatic test_pattern(input string name, input logic [1:0] pins, input logic tog,
                                input sample_t exp0, input sample_t exp1);
        int stray;
        sample_t exp_d;
        stray      = 0;
        pin_static = pins;
        toggle_en  = tog;
        adc_ready  = 1'b1;
        reset_dut(2);
        for (int c = 0; c < FIRST + 3 * BOSR; c++) begin
            int ph;
            ph = (c >= FIRST) ? (c - FIRST) % BOSR : BOSR;
            if (ph < NUM_CH) begin
                exp_d = (ph == 0) ? exp0 : exp1;
                n_chk++; if (adc_valid !== 1'b1) begin n_fail++; $display("FAIL %s_valid c=%0d: got %b, expected 1", name, c, adc_valid); end
                n_chk++; if (adc_ch !== 1'(ph)) begin n_fail++; $display("FAIL %s_ch c=%0d: got %0d, expected %0d", name, c, adc_ch, ph); end
                n_chk++; if (adc_data !== exp_d) begin n_fail++; $display("FAIL %s_data c=%0d: got %0d, expected %0d", name, c, adc_data, exp_d); end
            end else if (adc_valid) begin
                stray++;
            end
            step();
        end
        n_chk++; if (stray !== 0) begin n_fail++; $display("FAIL %s_stray_valid: got %0d, expected 0", name, stray); end
        n_chk++; if (adc_overflow !== 1'b0) begin n_fail++; $display("FAIL %s_ovf: got %b, expected 0", name, adc_overflow); end
        toggle_en = 1'b0;
    endtask

    task automatic test_simultaneous();
        pin_static = 2'b01;
        adc_ready  = 1'b1;
        reset_dut(2);
        repeat (FIRST + 1) step();
        adc_ready = 1'b0;
        for (int c = FIRST + 1; c < 1539; c++) step();
        // cycle 1539: next frame lands as channel 1 is finally accepted
        n_chk++; if (adc_ch !== 1'b1) begin n_fail++; $display("FAIL simul_pre_ch: got %0d, expected 1", adc_ch); end
        adc_ready = 1'b1;
        step();
        n_chk++; if (adc_valid !== 1'b1) begin n_fail++; $display("FAIL simul_valid: got %b, expected 1", adc_valid); end
        n_chk++; if (adc_ch !== 1'b0) begin n_fail++; $display("FAIL simul_ch0: got %0d, expected 0", adc_ch); end
        n_chk++; if (adc_data !== MAXP) begin n_fail++; $display("FAIL simul_data0: got %0d, expected %0d", adc_data, MAXP); end
        n_chk++; if (adc_overflow !== 1'b0) begin n_fail++; $display("FAIL simul_ovf: got %b, expected 0", adc_overflow); end
        step();
        n_chk++; if (adc_data !== MINN || adc_ch !== 1'b1) begin n_fail++; $display("FAIL simul_ch1: got ch %0d data %0d, expected ch 1 data %0d", adc_ch, adc_data, MINN); end
        step();
        n_chk++; if (adc_valid !== 1'b0) begin n_fail++; $display("FAIL simul_drop_valid: got %b, expected 0", adc_valid); end
    endtask

    task automatic test_backpressure();
        int bad;
        int stray;
        bad        = 0;
        stray      = 0;
        pin_static = 2'b01;
        adc_ready  = 1'b1;
        reset_dut(2);
        repeat (FIRST + 1) step();
        // cycle 1285: channel 1 presented, stall 600 cycles and swap pin levels
        adc_ready  = 1'b0;
        pin_static = 2'b10;
        n_chk++; if (adc_overflow !== 1'b0) begin n_fail++; $display("FAIL bp_ovf_pre: got %b, expected 0", adc_overflow); end
        for (int c = 0; c < 600; c++) begin
            if (adc_valid !== 1'b1 || adc_ch !== 1'b1 || adc_data !== MINN) bad++;
            step();
        end
        n_chk++; if (bad !== 0) begin n_fail++; $display("FAIL bp_hold: got %0d unstable cycles, expected 0", bad); end
        n_chk++; if (adc_overflow !== 1'b1) begin n_fail++; $display("FAIL bp_ovf: got %b, expected 1", adc_overflow); end
        adc_ready = 1'b1;
        step();
        n_chk++; if (adc_valid !== 1'b0) begin n_fail++; $display("FAIL bp_release_valid: got %b, expected 0", adc_valid); end
        for (int c = 1886; c < 2052; c++) begin
            if (adc_valid) stray++;
            step();
        end
        n_chk++; if (stray !== 0) begin n_fail++; $display("FAIL bp_stray_valid: got %0d, expected 0", stray); end
        n_chk++; if (adc_valid !== 1'b1 || adc_ch !== 1'b0) begin n_fail++; $display("FAIL bp_next_ch0: got valid %b ch %0d, expected valid 1 ch 0", adc_valid, adc_ch); end
        step();
        n_chk++; if (adc_valid !== 1'b1 || adc_ch !== 1'b1) begin n_fail++; $display("FAIL bp_next_ch1: got valid %b ch %0d, expected valid 1 ch 1", adc_valid, adc_ch); end
        for (int c = 2053; c < 2308; c++) step();
        n_chk++; if (adc_ch !== 1'b0 || adc_data !== MINN) begin n_fail++; $display("FAIL bp_swap_ch0: got ch %0d data %0d, expected ch 0 data %0d", adc_ch, adc_data, MINN); end
        step();
        n_chk++; if (adc_ch !== 1'b1 || adc_data !== MAXP) begin n_fail++; $display("FAIL bp_swap_ch1: got ch %0d data %0d, expected ch 1 data %0d", adc_ch, adc_data, MAXP); end
        n_chk++; if (adc_overflow !== 1'b1) begin n_fail++; $display("FAIL bp_ovf_sticky: got %b, expected 1", adc_overflow); end
    endtask

    task automatic test_rst_mid();
        int stray;
        stray      = 0;
        pin_static = 2'b01;
        adc_ready  = 1'b1;
        reset_dut(2);
        repeat (FIRST + 1) step();
        adc_ready = 1'b0;
        for (int c = FIRST + 1; c < 1545; c++) step();
        n_chk++; if (adc_ch !== 1'b1 || adc_overflow !== 1'b1) begin n_fail++; $display("FAIL rmid_pre: got ch %0d ovf %b, expected ch 1 ovf 1", adc_ch, adc_overflow); end
        adc_ready = 1'b1;
        reset_dut(1);
        n_chk++; if (adc_valid !== 1'b0) begin n_fail++; $display("FAIL rmid_valid: got %b, expected 0", adc_valid); end
        n_chk++; if (adc_ch !== 1'b0 || adc_data !== 16'sd0) begin n_fail++; $display("FAIL rmid_outs: got ch %0d data %0d, expected 0 0", adc_ch, adc_data); end
        n_chk++; if (adc_overflow !== 1'b0) begin n_fail++; $display("FAIL rmid_ovf: got %b, expected 0", adc_overflow); end
        for (int c = 0; c < FIRST; c++) begin
            if (adc_valid) stray++;
            step();
        end
        n_chk++; if (stray !== 0) begin n_fail++; $display("FAIL rmid_warmup: got %0d valid cycles, expected 0", stray); end
        n_chk++; if (adc_valid !== 1'b1 || adc_ch !== 1'b0 || adc_data !== MAXP) begin n_fail++; $display("FAIL rmid_resume: got valid %b ch %0d data %0d, expected 1 0 %0d", adc_valid, adc_ch, adc_data, MAXP); end
    endtask

    initial begin
        n_chk      = 0;
        n_fail     = 0;
        rst        = 1'b1;
        adc_ready  = 1'b1;
        toggle_en  = 1'b0;
        pin_static = 2'b00;
        test_reset();
        test_pattern("zeros",  2'b00, 1'b0, MINN, MINN);
        test_pattern("ones",   2'b11, 1'b0, MAXP, MAXP);
        test_pattern("toggle", 2'b00, 1'b1, 16'sd0, 16'sd0);
        test_pattern("mixed",  2'b01, 1'b0, MAXP, MINN);
        test_simultaneous();
        test_backpressure();
        test_rst_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
